clock_setter: RTL and testbench

- Front-end editor for the time/date counter.
- Takes the raw butt_increase / butt_decrease / butt_change pushbuttons, debounces them and steps through the time and date fields one at a time.
- Edits a shadow copy of the time and date, then issues a one-cycle load pulse with the new values to the counter.
- It is the writer side of the counter's time/date registers: the counter consumes set_* on load; this block produces them.

---
 rtl/clock_setter.sv | 203 ++++++++++++++++++++
 tb/tb_clock_setter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/clock_setter.sv
// Time/date editor: debounces the three pushbuttons, edits a shadow copy of the
// counter fields one at a time and pulses load when the edit sequence completes.
module clock_setter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESET_YEAR      = 2024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        butt_increase,
  input  logic        butt_decrease,
  input  logic        butt_change,
  input  logic [5:0]  cur_sec,
  input  logic [5:0]  cur_min,
  input  logic [4:0]  cur_hour,
  input  logic [4:0]  cur_day,
  input  logic [3:0]  cur_month,
  input  logic [13:0] cur_year,
  output logic [5:0]  set_sec,
  output logic [5:0]  set_min,
  output logic [4:0]  set_hour,
  output logic [4:0]  set_day,
  output logic [3:0]  set_month,
  output logic [13:0] set_year,
  output logic        load,
  output logic        editing,
  output logic [2:0]  field_sel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    E_HOUR  = 3'd1,
    E_MIN   = 3'd2,
    E_SEC   = 3'd3,
    E_DAY   = 3'd4,
    E_MONTH = 3'd5,
    E_YEAR  = 3'd6
  } state_t;

  function automatic logic [4:0] dim(input logic [3:0] m, input logic [13:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] clamp_day(input logic [4:0] d, input logic [4:0] lim);
    clamp_day = (d > lim) ? lim : d;
  endfunction

  // Bit order everywhere below: [0] increase, [1] decrease, [2] change.
  logic [2:0]    raw, sync1, sync2, deb, deb_d, ev;
  logic [CW-1:0] cnt [3];

  assign raw = {butt_change, butt_decrease, butt_increase};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      ev    <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      ev    <= deb & ~deb_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Change has priority; inc and dec together cancel.
  logic chg, inc, dec;
  assign chg = ev[2];
  assign inc = ev[0] & ~ev[1] & ~ev[2];
  assign dec = ev[1] & ~ev[0] & ~ev[2];

  state_t      state, state_n;
  logic [5:0]  sec, sec_n, min, min_n;
  logic [4:0]  hour, hour_n, day, day_n;
  logic [3:0]  month, month_n;
  logic [13:0] year, year_n;
  logic        load_n;

  logic [3:0]  cap_month;
  logic [13:0] cap_year;
  logic [4:0]  cap_dim, cap_day, cur_dim;

  assign cap_month = (cur_month == 4'd0 || cur_month > 4'd12) ? 4'd1 : cur_month;
  assign cap_year  = (cur_year > 14'd9999) ? 14'd0 : cur_year;
  assign cap_dim   = dim(cap_month, cap_year);
  assign cap_day   = (cur_day == 5'd0) ? 5'd1 : clamp_day(cur_day, cap_dim);
  assign cur_dim   = dim(month, year);

  always_comb begin
    state_n = state;
    sec_n   = sec;
    min_n   = min;
    hour_n  = hour;
    day_n   = day;
    month_n = month;
    year_n  = year;
    load_n  = 1'b0;
    case (state)
      RUN: if (chg) begin
        sec_n   = (cur_sec > 6'd59) ? 6'd0 : cur_sec;
        min_n   = (cur_min > 6'd59) ? 6'd0 : cur_min;
        hour_n  = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
        day_n   = cap_day;
        month_n = cap_month;
        year_n  = cap_year;
        state_n = E_HOUR;
      end
      E_HOUR: begin
        if (chg)      state_n = E_MIN;
        else if (inc) hour_n = (hour >= 5'd23) ? 5'd0 : hour + 5'd1;
        else if (dec) hour_n = (hour == 5'd0) ? 5'd23 : hour - 5'd1;
      end
      E_MIN: begin
        if (chg)      state_n = E_SEC;
        else if (inc) min_n = (min >= 6'd59) ? 6'd0 : min + 6'd1;
        else if (dec) min_n = (min == 6'd0) ? 6'd59 : min - 6'd1;
      end
      E_SEC: begin
        if (chg)      state_n = E_DAY;
        else if (inc) sec_n = (sec >= 6'd59) ? 6'd0 : sec + 6'd1;
        else if (dec) sec_n = (sec == 6'd0) ? 6'd59 : sec - 6'd1;
      end
      E_DAY: begin
        if (chg)      state_n = E_MONTH;
        else if (inc) day_n = (day >= cur_dim) ? 5'd1 : day + 5'd1;
        else if (dec) day_n = (day <= 5'd1) ? cur_dim : day - 5'd1;
      end
      E_MONTH: begin
        if (chg) state_n = E_YEAR;
        else if (inc || dec) begin
          if (inc) month_n = (month >= 4'd12) ? 4'd1 : month + 4'd1;
          else     month_n = (month <= 4'd1) ? 4'd12 : month - 4'd1;
          day_n = clamp_day(day, dim(month_n, year));
        end
      end
      E_YEAR: begin
        if (chg) begin
          state_n = RUN;
          load_n  = 1'b1;
        end else if (inc || dec) begin
          if (inc) year_n = (year >= 14'd9999) ? 14'd0 : year + 14'd1;
          else     year_n = (year == 14'd0) ? 14'd9999 : year - 14'd1;
          day_n = clamp_day(day, dim(month, year_n));
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      sec     <= 6'd0;
      min     <= 6'd0;
      hour    <= 5'd0;
      day     <= 5'd1;
      month   <= 4'd1;
      year    <= 14'(RESET_YEAR);
      load    <= 1'b0;
      editing <= 1'b0;
    end else begin
      state   <= state_n;
      sec     <= sec_n;
      min     <= min_n;
      hour    <= hour_n;
      day     <= day_n;
      month   <= month_n;
      year    <= year_n;
      load    <= load_n;
      editing <= (state_n != RUN);
    end
  end

  assign set_sec   = sec;
  assign set_min   = min;
  assign set_hour  = hour;
  assign set_day   = day;
  assign set_month = month;
  assign set_year  = year;
  assign field_sel = state;

endmodule

// File: tb/tb_clock_setter.sv
// Directed bench for clock_setter: capture, wrap, month-length clamp, full walk
// with load pulse, bounce/simultaneous-button handling and mid-edit reset.
module tb_clock_setter;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        butt_increase = 1'b0, butt_decrease = 1'b0, butt_change = 1'b0;
  logic [5:0]  cur_sec = '0, cur_min = '0;
  logic [4:0]  cur_hour = '0, cur_day = 5'd1;
  logic [3:0]  cur_month = 4'd1;
  logic [13:0] cur_year = 14'd2000;
  logic [5:0]  set_sec, set_min;
  logic [4:0]  set_hour, set_day;
  logic [3:0]  set_month;
  logic [13:0] set_year;
  logic        load, editing;
  logic [2:0]  field_sel;

  int n_tests = 0;
  int n_fail  = 0;
  int load_cnt = 0;
  logic load_ok = 1'b1;

  clock_setter #(.DEBOUNCE_CYCLES(D), .RESET_YEAR(2024)) dut (
    .clk(clk), .rst(rst),
    .butt_increase(butt_increase), .butt_decrease(butt_decrease), .butt_change(butt_change),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
    .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .load(load), .editing(editing), .field_sel(field_sel)
  );

  always #5 clk = ~clk;

  // Load must only appear on the cycle the FSM is back in RUN.
  always @(negedge clk) begin
    if (load) begin
      load_cnt++;
      if (field_sel != 3'd0 || editing) load_ok = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // b = {change, decrease, increase}
  task automatic press(input logic [2:0] b);
    @(negedge clk);
    {butt_change, butt_decrease, butt_increase} = b;
    repeat (D + 6) @(negedge clk);
    {butt_change, butt_decrease, butt_increase} = 3'b000;
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic set_cur(input int h, input int m, input int s, input int d, input int mo, input int y);
    cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    cur_day = 5'(d); cur_month = 4'(mo); cur_year = 14'(y);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (field_sel !== 3'd0) begin n_fail++; $display("FAIL reset_field_sel: got %0d expected 0", field_sel); end
    n_tests++; if (editing !== 1'b0) begin n_fail++; $display("FAIL reset_editing: got %0d expected 0", editing); end
    n_tests++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %0d expected 0", load); end
    n_tests++; if ({set_hour, set_min, set_sec} !== 17'd0) begin n_fail++; $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", set_hour, set_min, set_sec); end
    n_tests++; if (set_day !== 5'd1 || set_month !== 4'd1) begin n_fail++; $display("FAIL reset_date: got %0d/%0d expected 1/1", set_day, set_month); end
    n_tests++; if (set_year !== 14'd2024) begin n_fail++; $display("FAIL reset_year: got %0d expected 2024", set_year); end
  endtask

  task automatic test_capture();
    set_cur(13, 45, 10, 15, 6, 2030);
    @(negedge clk); butt_change = 1'b1;
    repeat (D + 3) @(negedge clk);
    n_tests++; if (field_sel !== 3'd0) begin n_fail++; $display("FAIL capture_early: got %0d expected 0", field_sel); end
    @(negedge clk);
    n_tests++; if (field_sel !== 3'd1) begin n_fail++; $display("FAIL capture_latency: got %0d expected 1", field_sel); end
    n_tests++; if (editing !== 1'b1) begin n_fail++; $display("FAIL capture_editing: got %0d expected 1", editing); end
    repeat (D + 4) @(negedge clk);
    butt_change = 1'b0;
    repeat (D + 6) @(negedge clk);
    n_tests++; if (field_sel !== 3'd1) begin n_fail++; $display("FAIL capture_hold_state: got %0d expected 1", field_sel); end
    n_tests++; if (set_hour !== 5'd13 || set_min !== 6'd45 || set_sec !== 6'd10) begin n_fail++; $display("FAIL capture_time: got %0d:%0d:%0d expected 13:45:10", set_hour, set_min, set_sec); end
    n_tests++; if (set_day !== 5'd15 || set_month !== 4'd6 || set_year !== 14'd2030) begin n_fail++; $display("FAIL capture_date: got %0d/%0d/%0d expected 15/6/2030", set_day, set_month, set_year); end
    n_tests++; if (load_cnt !== 0) begin n_fail++; $display("FAIL capture_load: got %0d expected 0", load_cnt); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    set_cur(31, 63, 60, 31, 4, 16000);
    press(3'b100);
    n_tests++; if ({set_hour, set_min, set_sec} !== 17'd0) begin n_fail++; $display("FAIL oor_time: got %0d:%0d:%0d expected 0:0:0", set_hour, set_min, set_sec); end
    n_tests++; if (set_day !== 5'd30 || set_month !== 4'd4 || set_year !== 14'd0) begin n_fail++; $display("FAIL oor_date: got %0d/%0d/%0d expected 30/4/0", set_day, set_month, set_year); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_cur(23, 59, 0, 31, 1, 2023);
    press(3'b100);
    press(3'b001);
    n_tests++; if (set_hour !== 5'd0) begin n_fail++; $display("FAIL hour_inc_wrap: got %0d expected 0", set_hour); end
    press(3'b010); press(3'b010);
    n_tests++; if (set_hour !== 5'd22) begin n_fail++; $display("FAIL hour_dec_wrap: got %0d expected 22", set_hour); end
    press(3'b100);
    press(3'b001);
    n_tests++; if (set_min !== 6'd0) begin n_fail++; $display("FAIL min_inc_wrap: got %0d expected 0", set_min); end
    press(3'b010); press(3'b010);
    n_tests++; if (set_min !== 6'd58) begin n_fail++; $display("FAIL min_dec_wrap: got %0d expected 58", set_min); end
    press(3'b100);
    press(3'b010);
    n_tests++; if (set_sec !== 6'd59) begin n_fail++; $display("FAIL sec_dec_wrap: got %0d expected 59", set_sec); end
    press(3'b001);
    n_tests++; if (set_sec !== 6'd0) begin n_fail++; $display("FAIL sec_inc_wrap: got %0d expected 0", set_sec); end
    press(3'b100); press(3'b100);
    n_tests++; if (field_sel !== 3'd5) begin n_fail++; $display("FAIL wrap_to_month: got %0d expected 5", field_sel); end
    press(3'b001);
    n_tests++; if (set_month !== 4'd2 || set_day !== 5'd28) begin n_fail++; $display("FAIL feb_clamp_2023: got %0d/%0d expected 28/2", set_day, set_month); end
  endtask

  task automatic test_walk_leap();
    do_reset();
    set_cur(0, 0, 0, 31, 1, 2024);
    load_cnt = 0; load_ok = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      press(3'b100);
      n_tests++; if (field_sel !== 3'(i)) begin n_fail++; $display("FAIL walk_state_%0d: got %0d expected %0d", i, field_sel, i); end
    end
    press(3'b001);
    n_tests++; if (set_month !== 4'd2 || set_day !== 5'd29) begin n_fail++; $display("FAIL feb_clamp_2024: got %0d/%0d expected 29/2", set_day, set_month); end
    press(3'b100);
    n_tests++; if (field_sel !== 3'd6) begin n_fail++; $display("FAIL walk_state_6: got %0d expected 6", field_sel); end
    press(3'b001);
    n_tests++; if (set_year !== 14'd2025 || set_day !== 5'd28) begin n_fail++; $display("FAIL year_clamp: got %0d day %0d expected 2025 day 28", set_year, set_day); end
    n_tests++; if (load_cnt !== 0) begin n_fail++; $display("FAIL walk_no_early_load: got %0d expected 0", load_cnt); end
    press(3'b100);
    n_tests++; if (field_sel !== 3'd0 || editing !== 1'b0) begin n_fail++; $display("FAIL walk_back_to_run: got state %0d editing %0d expected 0 0", field_sel, editing); end
    n_tests++; if (load_cnt !== 1 || load_ok !== 1'b1) begin n_fail++; $display("FAIL walk_load_pulse: got count %0d ok %0d expected 1 1", load_cnt, load_ok); end
    n_tests++; if ({set_hour, set_min, set_sec} !== 17'd0 || set_day !== 5'd28 || set_month !== 4'd2 || set_year !== 14'd2025) begin n_fail++; $display("FAIL walk_hold: got %0d:%0d:%0d %0d/%0d/%0d expected 0:0:0 28/2/2025", set_hour, set_min, set_sec, set_day, set_month, set_year); end
  endtask

  task automatic test_glitch_and_simultaneous();
    do_reset();
    set_cur(10, 20, 30, 10, 5, 2024);
    press(3'b100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); butt_increase = 1'b1;
      repeat (D - 2) @(negedge clk);
      butt_increase = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (D + 6) @(negedge clk);
    n_tests++; if (set_hour !== 5'd10) begin n_fail++; $display("FAIL glitch_ignored: got %0d expected 10", set_hour); end
    press(3'b011);
    n_tests++; if (set_hour !== 5'd10) begin n_fail++; $display("FAIL inc_dec_cancel: got %0d expected 10", set_hour); end
    press(3'b101);
    n_tests++; if (field_sel !== 3'd2 || set_hour !== 5'd10 || set_min !== 6'd20) begin n_fail++; $display("FAIL change_wins: got state %0d %0d:%0d expected 2 10:20", field_sel, set_hour, set_min); end
  endtask

  task automatic test_reset_mid_edit();
    int lc;
    press(3'b100); press(3'b100);
    press(3'b001);
    n_tests++; if (field_sel !== 3'd4 || set_day !== 5'd11) begin n_fail++; $display("FAIL mid_edit_day: got state %0d day %0d expected 4 11", field_sel, set_day); end
    lc = load_cnt;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_tests++; if (field_sel !== 3'd0 || editing !== 1'b0 || load !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state: got state %0d editing %0d load %0d expected 0 0 0", field_sel, editing, load); end
    n_tests++; if ({set_hour, set_min, set_sec} !== 17'd0 || set_day !== 5'd1 || set_month !== 4'd1 || set_year !== 14'd2024) begin n_fail++; $display("FAIL mid_reset_shadow: got %0d:%0d:%0d %0d/%0d/%0d expected 0:0:0 1/1/2024", set_hour, set_min, set_sec, set_day, set_month, set_year); end
    n_tests++; if (load_cnt !== lc) begin n_fail++; $display("FAIL mid_reset_no_load: got %0d expected %0d", load_cnt, lc); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_out_of_range();
    test_wrap();
    test_walk_leap();
    test_glitch_and_simultaneous();
    test_reset_mid_edit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
